// File: rtl/lfsr_run_ctrl.sv
// lfsr_run_ctrl: command sequencer for a variable-length Fibonacci LFSR.
// One command at a time. The controller seeds its own shift register,
// fetches the tap mask for the requested length, and then does one of two
// things: it streams a fixed number of feedback bits under backpressure
// (RUN), or it free-runs until the seed recurs (MEASURE). Every command,
// including a rejected or aborted one, produces exactly one response.
module lfsr_run_ctrl #(
    parameter int              W          = 34,
    parameter int              STEP_W     = 16,
    parameter longint unsigned MEAS_LIMIT = 64'h2_0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_mode,
    input  logic [5:0]        cmd_len,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic [W-1:0]      cmd_seed,
    input  logic              cmd_abort,
    output logic [5:0]        mask_len,
    input  logic              mask_valid,
    input  logic [W-1:0]      mask_value,
    output logic              bit_valid,
    input  logic              bit_ready,
    output logic              bit_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_status,
    output logic [W-1:0]      rsp_count,
    output logic [W-1:0]      rsp_state,
    output logic              busy
);

    localparam logic [W-1:0] ONE = W'(1);

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_BAD_LEN = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;
    localparam logic [1:0] ST_ABORTED = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_RUN,
        S_MEASURE,
        S_RESP
    } state_t;

    state_t st_q, st_d;

    // Registered command fields and datapath state
    logic              mode_q;
    logic [5:0]        len_q;
    logic [STEP_W-1:0] steps_q;
    logic [W-1:0]      lfsr_q;
    logic [W-1:0]      seed_q;
    logic [W-1:0]      mask_q;
    logic [W-1:0]      count_q;
    logic [1:0]        status_q;
    logic [5:0]        mask_len_q;

    // Control strobes from the FSM
    logic              load_cmd;
    logic              load_mask;
    logic              step_en;
    logic [1:0]        status_d;

    // Datapath nets
    logic [W-1:0]      lm_cmd;
    logic [W-1:0]      lm_q;
    logic [W-1:0]      seed_masked;
    logic [W-1:0]      seed_load;
    logic              fb;
    logic [W-1:0]      lfsr_nxt;
    logic [W-1:0]      count_inc;
    logic              run_done;
    logic              meas_recur;
    logic              meas_limit;

    // Active-length mask: the low len bits set. Lengths at or beyond the
    // register width wrap to all ones, which keeps the shift well defined.
    function automatic logic [W-1:0] len_mask(input logic [5:0] len);
        return (ONE << len) - ONE;
    endfunction

    // Feedback bit: mask bit k selects state bit k-1 as a tap.
    function automatic logic lfsr_feedback(input logic [W-1:0] s, input logic [W-1:0] m);
        return ^(s & (m >> 1));
    endfunction

    // One Fibonacci shift: feedback enters at bit 0, result clipped to length.
    function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] s, input logic f,
                                               input logic [W-1:0] lm);
        return {s[W-2:0], f} & lm;
    endfunction

    assign lm_cmd      = len_mask(cmd_len);
    assign lm_q        = len_mask(len_q);
    assign seed_masked = cmd_seed & lm_cmd;
    // An all-zero state would lock the LFSR, so a zero seed becomes 1.
    assign seed_load   = (seed_masked == '0) ? ONE : seed_masked;

    assign fb          = lfsr_feedback(lfsr_q, mask_q);
    assign lfsr_nxt    = lfsr_step(lfsr_q, fb, lm_q);
    assign count_inc   = count_q + ONE;

    assign run_done    = (count_inc == W'(steps_q));
    assign meas_recur  = (lfsr_nxt == seed_q);
    assign meas_limit  = (64'(count_inc) == MEAS_LIMIT);

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q <= S_IDLE;
        end else begin
            st_q <= st_d;
        end
    end

    // Next state and control strobes; abort only acts while stepping
    always_comb begin
        st_d      = st_q;
        load_cmd  = 1'b0;
        load_mask = 1'b0;
        step_en   = 1'b0;
        status_d  = status_q;
        case (st_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    load_cmd = 1'b1;
                    st_d     = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                load_mask = 1'b1;
                if (!mask_valid) begin
                    status_d = ST_BAD_LEN;
                    st_d     = S_RESP;
                end else if (mode_q) begin
                    st_d = S_MEASURE;
                end else if (steps_q == '0) begin
                    status_d = ST_OK;
                    st_d     = S_RESP;
                end else begin
                    st_d = S_RUN;
                end
            end
            S_RUN: begin
                if (cmd_abort) begin
                    status_d = ST_ABORTED;
                    st_d     = S_RESP;
                end else if (bit_ready) begin
                    step_en = 1'b1;
                    if (run_done) begin
                        status_d = ST_OK;
                        st_d     = S_RESP;
                    end
                end
            end
            S_MEASURE: begin
                if (cmd_abort) begin
                    status_d = ST_ABORTED;
                    st_d     = S_RESP;
                end else begin
                    step_en = 1'b1;
                    // Recurrence is checked first so it wins over the limit.
                    if (meas_recur) begin
                        status_d = ST_OK;
                        st_d     = S_RESP;
                    end else if (meas_limit) begin
                        status_d = ST_TIMEOUT;
                        st_d     = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    st_d = S_IDLE;
                end
            end
            default: begin
                st_d = S_IDLE;
            end
        endcase
    end

    // Command capture, mask capture, LFSR stepping and step counting
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q     <= 1'b0;
            len_q      <= '0;
            steps_q    <= '0;
            lfsr_q     <= '0;
            seed_q     <= '0;
            mask_q     <= '0;
            count_q    <= '0;
            status_q   <= ST_OK;
            mask_len_q <= '0;
        end else begin
            status_q <= status_d;
            if (load_cmd) begin
                mode_q     <= cmd_mode;
                len_q      <= cmd_len;
                steps_q    <= cmd_steps;
                mask_len_q <= cmd_len;
                lfsr_q     <= seed_load;
                seed_q     <= seed_load;
                count_q    <= '0;
            end
            if (load_mask) begin
                mask_q <= mask_value;
            end
            if (step_en) begin
                lfsr_q  <= lfsr_nxt;
                count_q <= count_inc;
            end
        end
    end

    // The state and count registers hold while in RESP, so they serve
    // directly as the stable response payload.
    assign cmd_ready  = (st_q == S_IDLE);
    assign busy       = (st_q != S_IDLE);
    assign mask_len   = mask_len_q;
    assign bit_valid  = (st_q == S_RUN);
    assign bit_data   = (st_q == S_RUN) ? fb : 1'b0;
    assign rsp_valid  = (st_q == S_RESP);
    assign rsp_status = status_q;
    assign rsp_count  = count_q;
    assign rsp_state  = lfsr_q;

endmodule

// File: tb/tb_lfsr_run_ctrl.sv
// tb_lfsr_run_ctrl: directed, table-driven bench for lfsr_run_ctrl with a
// small tap-mask lookup model (lengths 2..5 supported) and MEAS_LIMIT=7.
module tb_lfsr_run_ctrl;

    localparam int W = 34;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_mode;
    logic [5:0]    cmd_len;
    logic [15:0]   cmd_steps;
    logic [W-1:0]  cmd_seed;
    logic          cmd_abort;
    logic [5:0]    mask_len;
    logic          mask_valid;
    logic [W-1:0]  mask_value;
    logic          bit_valid;
    logic          bit_ready;
    logic          bit_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_status;
    logic [W-1:0]  rsp_count;
    logic [W-1:0]  rsp_state;
    logic          busy;

    always #5 clk = ~clk;

    lfsr_run_ctrl #(.W(W), .STEP_W(16), .MEAS_LIMIT(64'd7)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_mode   (cmd_mode),
        .cmd_len    (cmd_len),
        .cmd_steps  (cmd_steps),
        .cmd_seed   (cmd_seed),
        .cmd_abort  (cmd_abort),
        .mask_len   (mask_len),
        .mask_valid (mask_valid),
        .mask_value (mask_value),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .bit_data   (bit_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_status (rsp_status),
        .rsp_count  (rsp_count),
        .rsp_state  (rsp_state),
        .busy       (busy)
    );

    // Tap-mask lookup model
    always_comb begin
        mask_valid = 1'b0;
        mask_value = '0;
        case (mask_len)
            6'd2: begin mask_valid = 1'b1; mask_value = 34'b110;    end
            6'd3: begin mask_valid = 1'b1; mask_value = 34'b1100;   end
            6'd4: begin mask_valid = 1'b1; mask_value = 34'b11000;  end
            6'd5: begin mask_valid = 1'b1; mask_value = 34'b101000; end
            default: ;
        endcase
    end

    typedef struct {
        logic         mode;
        logic [5:0]   len;
        logic [15:0]  steps;
        logic [W-1:0] seed;
        int           stall;       // 1: bit_ready toggles
        int           abort_bits;  // abort once this many bits taken (-1 off)
        int           abort_t;     // abort at this cycle after accept (-1 off)
        int           hold;        // cycles to hold off rsp_ready
        logic [1:0]   e_status;
        logic [W-1:0] e_count;
        logic [W-1:0] e_state;
        int           e_nbits;
        logic [63:0]  e_bits;      // bit i = i-th emitted bit
        int           e_fb_lat;    // cycle of first bit_valid, -1 none
        int           e_rsp_lat;   // cycle of rsp_valid, -1 unchecked
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic run_cmd(input vec_t v, output logic [1:0] st, output logic [W-1:0] cnt,
                           output logic [W-1:0] sta, output int nbits,
                           output logic [63:0] bits, output int fb_lat, output int rsp_lat);
        int   t;
        logic done;
        logic stalled;
        logic stall_bit;
        nbits = 0; bits = '0; fb_lat = -1; rsp_lat = -1;
        st = '0; cnt = '0; sta = '0;
        stalled = 1'b0; stall_bit = 1'b0; done = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_mode  = v.mode;
        cmd_len   = v.len;
        cmd_steps = v.steps;
        cmd_seed  = v.seed;
        bit_ready = 1'b1;
        chk("accept_ready", 64'(cmd_ready), 64'd1);
        t = 1;
        while (t <= 400 && !done) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (t == 1) begin
                chk("busy_in_flight", 64'(busy), 64'd1);
                chk("no_ready_in_flight", 64'(cmd_ready), 64'd0);
            end
            if (rsp_valid) begin
                done = 1'b1;
                rsp_lat = t;
                st  = rsp_status;
                cnt = rsp_count;
                sta = rsp_state;
            end else begin
                if (bit_valid && fb_lat < 0) fb_lat = t;
                if (stalled && bit_valid) chk("stall_bit_hold", 64'(bit_data), 64'(stall_bit));
                bit_ready = (v.stall != 0) ? t[0] : 1'b1;
                cmd_abort = (v.abort_bits >= 0 && bit_valid && nbits == v.abort_bits) ||
                            (t == v.abort_t);
                if (bit_valid && bit_ready && !cmd_abort) begin
                    if (nbits < 64) bits[nbits] = bit_data;
                    nbits++;
                end
                stalled   = bit_valid && !bit_ready;
                stall_bit = bit_data;
            end
            t++;
        end
        if (!done) chk("rsp_wait_expired", 64'd0, 64'd1);
        cmd_abort = 1'b0;
        bit_ready = 1'b1;
        // Hold the response off; abort asserted here must have no effect.
        repeat (v.hold) begin
            cmd_abort = 1'b1;
            @(negedge clk);
            chk("rsp_hold_valid",  64'(rsp_valid),  64'd1);
            chk("rsp_hold_status", 64'(rsp_status), 64'(st));
            chk("rsp_hold_count",  64'(rsp_count),  64'(cnt));
            chk("rsp_hold_state",  64'(rsp_state),  64'(sta));
        end
        cmd_abort = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_drop", 64'(rsp_valid), 64'd0);
        chk("back_idle", 64'(cmd_ready), 64'd1);
    endtask

    task automatic check_vec(input int i, input vec_t v);
        logic [1:0]   st;
        logic [W-1:0] cnt;
        logic [W-1:0] sta;
        int           nbits;
        logic [63:0]  bits;
        int           fb_lat;
        int           rsp_lat;
        run_cmd(v, st, cnt, sta, nbits, bits, fb_lat, rsp_lat);
        chk($sformatf("v%0d_status", i), 64'(st),     64'(v.e_status));
        chk($sformatf("v%0d_count", i),  64'(cnt),    64'(v.e_count));
        chk($sformatf("v%0d_state", i),  64'(sta),    64'(v.e_state));
        chk($sformatf("v%0d_nbits", i),  64'(nbits),  64'(v.e_nbits));
        chk($sformatf("v%0d_bits", i),   bits,        v.e_bits);
        chk($sformatf("v%0d_fb_lat", i), 64'(fb_lat), 64'(v.e_fb_lat));
        if (v.e_rsp_lat >= 0)
            chk($sformatf("v%0d_rsp_lat", i), 64'(rsp_lat), 64'(v.e_rsp_lat));
    endtask

    initial begin
        //          mode len steps seed        stl abb abt hld  st    cnt  state       nb  bits          fb  rsp
        vecs[0] = '{1'b1, 6'd3, 16'd0,   34'h1,   0, -1, -1, 0, 2'd0, 34'd7,  34'h1,   0, 64'h0,   -1,  9};
        vecs[1] = '{1'b0, 6'd4, 16'd5,   34'h1,   0, -1, -1, 0, 2'd0, 34'd5,  34'h6,   5, 64'h0C,   2,  7};
        vecs[2] = '{1'b0, 6'd4, 16'd5,   34'h1,   1, -1, -1, 2, 2'd0, 34'd5,  34'h6,   5, 64'h0C,   2, 12};
        vecs[3] = '{1'b0, 6'd8, 16'd3,   34'h1AB, 0, -1, -1, 0, 2'd1, 34'd0,  34'hAB,  0, 64'h0,   -1,  2};
        vecs[4] = '{1'b0, 6'd3, 16'd0,   34'h0,   0, -1, -1, 0, 2'd0, 34'd0,  34'h1,   0, 64'h0,   -1,  2};
        vecs[5] = '{1'b1, 6'd5, 16'd0,   34'h1,   0, -1, -1, 0, 2'd2, 34'd7,  34'd22,  0, 64'h0,   -1,  9};
        vecs[6] = '{1'b1, 6'd2, 16'd0,   34'h1,   0, -1, -1, 0, 2'd0, 34'd3,  34'h1,   0, 64'h0,   -1,  5};
        vecs[7] = '{1'b0, 6'd4, 16'd100, 34'h1,   0, 10, -1, 3, 2'd3, 34'd10, 34'h7,  10, 64'h3AC,  2, 13};
        vecs[8] = '{1'b1, 6'd5, 16'd0,   34'h1,   0, -1,  4, 0, 2'd3, 34'd2,  34'h4,   0, 64'h0,   -1,  5};
        vecs[9] = '{1'b1, 6'd3, 16'd0,   34'h1F,  0, -1, -1, 0, 2'd0, 34'd7,  34'h7,   0, 64'h0,   -1,  9};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_mode = 1'b0; cmd_len = '0; cmd_steps = '0;
        cmd_seed = '0; cmd_abort = 1'b0; bit_ready = 1'b1; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready",  64'(cmd_ready),  64'd1);
        chk("rst_busy",       64'(busy),       64'd0);
        chk("rst_bit_valid",  64'(bit_valid),  64'd0);
        chk("rst_rsp_valid",  64'(rsp_valid),  64'd0);
        chk("rst_rsp_status", 64'(rsp_status), 64'd0);
        chk("rst_rsp_count",  64'(rsp_count),  64'd0);
        chk("rst_rsp_state",  64'(rsp_state),  64'd0);
        chk("rst_mask_len",   64'(mask_len),   64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            check_vec(i, vecs[i]);
        end

        // Reset in the middle of a long RUN drops the command silently
        @(negedge clk);
        cmd_valid = 1'b1; cmd_mode = 1'b0; cmd_len = 6'd4; cmd_steps = 16'd100;
        cmd_seed = 34'h1; bit_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrun_bit_valid", 64'(bit_valid), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrun_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("midrun_rst_bit_valid", 64'(bit_valid), 64'd0);
        chk("midrun_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("midrun_rst_busy",      64'(busy),      64'd0);
        chk("midrun_rst_mask_len",  64'(mask_len),  64'd0);
        chk("midrun_rst_count",     64'(rsp_count), 64'd0);
        repeat (2) @(negedge clk);
        chk("midrun_no_rsp", 64'(rsp_valid), 64'd0);

        // A fresh command after the reset behaves normally
        check_vec(1, vecs[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
